// File: rtl/ct_spsram_1024x32_ctrl.sv
// Two-requester round-robin sequencer for the single-port 1024x32 SRAM wrapper.
// Define CT_SPSRAM_CTRL_INIT_EN to zero-fill (INIT_VALUE) the array after every reset.
module ct_spsram_1024x32_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    p0_req,
  input  logic                    p0_wr,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_wbe,
  input  logic                    p1_req,
  input  logic                    p1_wr,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_wbe,
  output logic                    p0_gnt,
  output logic                    p1_gnt,
  output logic                    p0_rvld,
  output logic                    p1_rvld,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   A,
  output logic                    CEN,
  output logic                    GWEN,
  output logic [DATA_WIDTH-1:0]   D,
  output logic [DATA_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0]   Q
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic                  rr_last_reg, rr_last_next;
  logic                  p0_rvld_reg, p1_rvld_reg;
  logic                  run_active;
  logic                  sel_wr;
  logic [BE_WIDTH-1:0]   sel_wbe;
  logic [DATA_WIDTH-1:0] byte_wen;
`ifdef CT_SPSRAM_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
`endif

  // Grants are masked while RST is high so nothing issues in the reset cycle.
  assign run_active = (state_reg == ST_RUN) && !RST;
  assign p0_gnt     = run_active && p0_req && (!p1_req || rr_last_reg);
  assign p1_gnt     = run_active && p1_req && (!p0_req || !rr_last_reg);
  assign sel_wr     = p1_gnt ? p1_wr  : p0_wr;
  assign sel_wbe    = p1_gnt ? p1_wbe : p0_wbe;
  assign init_done  = run_active;
  assign p0_rvld    = p0_rvld_reg;
  assign p1_rvld    = p1_rvld_reg;
  assign rdata      = Q;

  genvar gi;
  generate
    for (gi = 0; gi < BE_WIDTH; gi++) begin : g_byte_wen
      assign byte_wen[8*gi +: 8] = {8{~sel_wbe[gi]}};
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    rr_last_next = rr_last_reg;
    A            = p1_gnt ? p1_addr  : p0_addr;
    D            = p1_gnt ? p1_wdata : p0_wdata;
    CEN          = 1'b1;
    GWEN         = 1'b1;
    WEN          = '1;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    cnt_next     = cnt_reg;
`endif
    if (p0_gnt || p1_gnt) begin
      CEN          = 1'b0;
      GWEN         = !sel_wr;
      WEN          = sel_wr ? byte_wen : '1;
      rr_last_next = p1_gnt;
    end
`ifdef CT_SPSRAM_CTRL_INIT_EN
    if (state_reg == ST_INIT) begin
      A        = cnt_reg;
      D        = INIT_VALUE;
      CEN      = 1'b0;
      GWEN     = 1'b0;
      WEN      = '0;
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == '1) begin
        state_next = ST_RUN;
      end
    end
`else
    state_next = ST_RUN;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
`else
      state_reg <= ST_RUN;
`endif
      rr_last_reg <= 1'b1;
      p0_rvld_reg <= 1'b0;
      p1_rvld_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
`ifdef CT_SPSRAM_CTRL_INIT_EN
      cnt_reg     <= cnt_next;
`endif
      rr_last_reg <= rr_last_next;
      p0_rvld_reg <= p0_gnt && !p0_wr;
      p1_rvld_reg <= p1_gnt && !p1_wr;
    end
  end

endmodule

// File: tb/tb_ct_spsram_1024x32_ctrl.sv
// Directed bench for ct_spsram_1024x32_ctrl with a behavioural SRAM model on A/CEN/GWEN/WEN/D/Q.
// Covers both builds of CT_SPSRAM_CTRL_INIT_EN.
module tb_ct_spsram_1024x32_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        p0_req, p0_wr, p1_req, p1_wr;
  logic [9:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [3:0]  p0_wbe, p1_wbe;
  logic        p0_gnt, p1_gnt, p0_rvld, p1_rvld, init_done;
  logic [31:0] rdata;
  logic [9:0]  A;
  logic        CEN, GWEN;
  logic [31:0] D, WEN, Q;

  logic [31:0] mem [0:1023] = '{default: 32'hFFFF_FFFF};
  logic [31:0] q_reg;
  int          n_cmp;
  int          n_bad;

`ifdef CT_SPSRAM_CTRL_INIT_EN
  localparam logic [31:0] FIRST_RD = 32'h0000_0000;
`else
  localparam logic [31:0] FIRST_RD = 32'hFFFF_FFFF;
`endif

  always #5 CLK = ~CLK;

  // Single-port SRAM: bit-masked write, registered read.
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      else       q_reg  <= mem[A];
    end
  end
  assign Q = q_reg;

  ct_spsram_1024x32_ctrl dut (
    .CLK(CLK), .RST(RST),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wbe(p0_wbe),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wbe(p1_wbe),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvld(p0_rvld), .p1_rvld(p1_rvld),
    .rdata(rdata), .init_done(init_done),
    .A(A), .CEN(CEN), .GWEN(GWEN), .D(D), .WEN(WEN), .Q(Q)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

`ifdef CT_SPSRAM_CTRL_INIT_EN
  task automatic fill_check(input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (CEN !== 1'b0 || GWEN !== 1'b0 || WEN !== 32'h0 || A !== i[9:0] || D !== 32'h0 ||
          p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || init_done !== 1'b0) bad++;
      step();
    end
    check_val(tag, bad, 0);
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0;
    RST = 1'b1;
    p0_req = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0; p0_wbe = '0;
    p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0; p1_wbe = '0;
    repeat (2) @(posedge CLK);
    #1;
    // p0 requests a read of 0x005 during reset and holds it
    p0_req = 1; p0_wr = 0; p0_addr = 10'h005;
    #1;
    check_val("rst_p0_gnt", p0_gnt, 0);
    check_val("rst_p1_gnt", p1_gnt, 0);
    check_val("rst_rvld", {p0_rvld, p1_rvld}, 0);
    check_val("rst_init_done", init_done, 0);
`ifdef CT_SPSRAM_CTRL_INIT_EN
    check_val("rst_cen", CEN, 0);
    check_val("rst_wen", WEN, 32'h0);
    check_val("rst_a", A, 0);
    check_val("rst_d", D, 32'h0);
`else
    check_val("rst_cen", CEN, 1);
    check_val("rst_gwen", GWEN, 1);
    check_val("rst_wen", WEN, 32'hFFFF_FFFF);
`endif
    RST = 1'b0;
    #1;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    fill_check(1024, "fill");
`endif
    check_val("first_init_done", init_done, 1);
    check_val("first_gnt", p0_gnt, 1);
    check_val("first_gwen", GWEN, 1);
    step(); p0_req = 0;
    check_val("first_p0_rvld", p0_rvld, 1);
    check_val("first_p1_rvld", p1_rvld, 0);
    check_val("first_rdata", rdata, FIRST_RD);

    // p0 full write, p1 readback of 0x3FF
    p0_req = 1; p0_wr = 1; p0_addr = 10'h3FF; p0_wdata = 32'hDEAD_BEEF; p0_wbe = 4'hF;
    #1;
    check_val("wr_gnt", p0_gnt, 1);
    check_val("wr_cen", CEN, 0);
    check_val("wr_gwen", GWEN, 0);
    check_val("wr_wen", WEN, 32'h0);
    check_val("wr_a", A, 10'h3FF);
    check_val("wr_d", D, 32'hDEAD_BEEF);
    step(); p0_req = 0;
    check_val("wr_no_rvld", p0_rvld, 0);
    p1_req = 1; p1_wr = 0; p1_addr = 10'h3FF;
    #1;
    check_val("rd_p1_gnt", p1_gnt, 1);
    check_val("rd_p0_gnt", p0_gnt, 0);
    check_val("rd_gwen", GWEN, 1);
    check_val("rd_wen", WEN, 32'hFFFF_FFFF);
    step(); p1_req = 0;
    check_val("rd_p1_rvld", p1_rvld, 1);
    check_val("rd_p0_rvld", p0_rvld, 0);
    check_val("rd_rdata", rdata, 32'hDEAD_BEEF);
    #1;
    check_val("idle_cen", CEN, 1);
    check_val("idle_gwen", GWEN, 1);
    check_val("idle_wen", WEN, 32'hFFFF_FFFF);
    step();
    check_val("rvld_one_cycle", p1_rvld, 0);

    // Partial write over zero, then wbe=0 write must leave the word alone
    p0_req = 1; p0_wr = 1; p0_addr = 10'h010; p0_wdata = 32'h0; p0_wbe = 4'hF;
    step(); p0_req = 0;
    p1_req = 1; p1_wr = 1; p1_addr = 10'h010; p1_wdata = 32'hAABB_CCDD; p1_wbe = 4'b0101;
    #1;
    check_val("pw_gnt", p1_gnt, 1);
    check_val("pw_wen", WEN, 32'hFF00_FF00);
    check_val("pw_d", D, 32'hAABB_CCDD);
    step(); p1_req = 0;
    p0_req = 1; p0_wr = 0;
    step(); p0_req = 0;
    check_val("pw_rvld", p0_rvld, 1);
    check_val("pw_rdata", rdata, 32'h00BB_00DD);
    p0_req = 1; p0_wr = 1; p0_wdata = 32'hFFFF_FFFF; p0_wbe = 4'h0;
    #1;
    check_val("be0_cen", CEN, 0);
    check_val("be0_gwen", GWEN, 0);
    check_val("be0_wen", WEN, 32'hFFFF_FFFF);
    step(); p0_req = 0;
    p0_req = 1; p0_wr = 0;
    step(); p0_req = 0;
    check_val("be0_rdata", rdata, 32'h00BB_00DD);
    p1_req = 1; p1_wr = 0; p1_addr = 10'h3FF;
    step(); p1_req = 0;
    check_val("p1_rd2_rdata", rdata, 32'hDEAD_BEEF);

    // Both ports hold reads: grants alternate starting with p0
    p0_req = 1; p0_wr = 0; p0_addr = 10'h3FF;
    p1_req = 1; p1_wr = 0; p1_addr = 10'h010;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        check_val("tie_p0_rvld", p0_rvld, (i % 2 == 1));
        check_val("tie_p1_rvld", p1_rvld, (i % 2 == 0));
        check_val("tie_rdata", rdata, (i % 2 == 1) ? 32'hDEAD_BEEF : 32'h00BB_00DD);
      end
      #1;
      check_val("tie_p0_gnt", p0_gnt, (i % 2 == 0));
      check_val("tie_p1_gnt", p1_gnt, (i % 2 == 1));
      step();
    end
    p0_req = 0; p1_req = 0;
    check_val("tie_last_p1_rvld", p1_rvld, 1);
    check_val("tie_last_p0_rvld", p0_rvld, 0);
    check_val("tie_last_rdata", rdata, 32'h00BB_00DD);

    // Reset right after a granted read
    p0_req = 1; p0_wr = 0; p0_addr = 10'h3FF;
    step();
    RST = 1'b1;
    #1;
    check_val("rstrd_rvld_pre", p0_rvld, 1);
    check_val("rstrd_gnt", p0_gnt, 0);
    step();
    check_val("rstrd_rvld_clr", p0_rvld, 0);
    p0_req = 0;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    RST = 1'b0;
    #1;
    fill_check(500, "fill_part");
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    fill_check(1024, "refill");
    check_val("refill_done", init_done, 1);
    p0_req = 1; p0_wr = 0; p0_addr = 10'h3FF;
    step(); p0_req = 0;
    check_val("refill_rdata_3ff", rdata, 32'h0);
    p1_req = 1; p1_wr = 0; p1_addr = 10'h010;
    step(); p1_req = 0;
    check_val("refill_rdata_010", rdata, 32'h0);
`else
    p0_req = 1; p0_wr = 0; p0_addr = 10'h3FF;
    RST = 1'b0;
    #1;
    check_val("noinit_done", init_done, 1);
    check_val("noinit_gnt", p0_gnt, 1);
    step(); p0_req = 0;
    check_val("noinit_rvld", p0_rvld, 1);
    check_val("noinit_rdata", rdata, 32'hDEAD_BEEF);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
